// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pin bundle between an initiator (master)
// and the flash responder (slave).
interface spi_flash_responder_if;
  logic s_sclk;
  logic s_cs;
  logic s_mosi;
  logic s_miso;

  modport master (
    output s_sclk, s_cs, s_mosi,
    input  s_miso
  );

  modport slave (
    input  s_sclk, s_cs, s_mosi,
    output s_miso
  );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target (WREN/RDSR/PP/READ/CE).
// Define SPI_RESP_FAST_READ_EN to accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
  parameter int MEM_BYTES   = 256,
  parameter int BUSY_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  spi_flash_responder_if.slave spi,
  output logic wip,
  output logic wel
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(BUSY_CYCLES + 1);
  localparam logic [AW-1:0] PMASK = AW'(255);

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_CE    = 8'h60;
`ifdef SPI_RESP_FAST_READ_EN
  localparam logic [7:0] OP_FREAD = 8'h0b;
`endif

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, PP_DATA, STATUS, IGNORE
`ifdef SPI_RESP_FAST_READ_EN
    , DUMMY
`endif
  } state_t;

  typedef enum logic [1:0] {
    BG_IDLE, PROG_RUN, ERASE_RUN
  } bg_t;

  state_t state, nxt;
  bg_t    bg;

  logic [1:0]    sclk_q, cs_q, mosi_q;
  logic          sclk_d, cs_d;
  logic          sclk_s, cs_s, mosi_s;
  logic          rise, fall, cs_fall, cs_rise;
  logic [5:0]    bits;
  logic [2:0]    idx;
  logic [6:0]    sh;
  logic [7:0]    rx_byte, op, tx, status, src;
  logic [AW-1:0] addr, ea;
  logic [CW-1:0] cnt;
  logic          pp_done, pp_we, miso;
  logic [7:0]    mem [MEM_BYTES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[0], spi.s_sclk};
      cs_q   <= {cs_q[0], spi.s_cs};
      mosi_q <= {mosi_q[0], spi.s_mosi};
      sclk_d <= sclk_q[1];
      cs_d   <= cs_q[1];
    end
  end

  assign sclk_s  = sclk_q[1];
  assign cs_s    = cs_q[1];
  assign mosi_s  = mosi_q[1];
  assign rise    = sclk_s & ~sclk_d & ~cs_s;
  assign fall    = ~sclk_s & sclk_d & ~cs_s;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;

  assign idx     = bits[2:0];
  assign rx_byte = {sh, mosi_s};
  assign status  = {6'b0, wel, wip};
  assign src     = (state == STATUS) ? status : mem[addr];
  assign pp_we   = rise & (state == PP_DATA) & (idx == 3'd7);
  assign wip     = (bg != BG_IDLE);
  assign spi.s_miso = miso;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (cs_s) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (cs_fall) nxt = CMD;
        CMD: if (rise && bits == 6'd7) begin
          // a busy part answers nothing but status reads
          if (wip && rx_byte != OP_RDSR) begin
            nxt = IGNORE;
          end else begin
            unique case (1'b1)
              rx_byte == OP_READ:  nxt = ADDR;
`ifdef SPI_RESP_FAST_READ_EN
              rx_byte == OP_FREAD: nxt = ADDR;
`endif
              rx_byte == OP_PP:    nxt = wel ? ADDR : IGNORE;
              rx_byte == OP_RDSR:  nxt = STATUS;
              default:             nxt = IGNORE;
            endcase
          end
        end
        ADDR: if (rise && bits == 6'd31) begin
          nxt = (op == OP_READ) ? RD_DATA : PP_DATA;
`ifdef SPI_RESP_FAST_READ_EN
          if (op == OP_FREAD) nxt = DUMMY;
`endif
        end
`ifdef SPI_RESP_FAST_READ_EN
        DUMMY: if (rise && bits == 6'd39) nxt = RD_DATA;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits    <= '0;
      sh      <= '0;
      op      <= '0;
      addr    <= '0;
      tx      <= '0;
      miso    <= 1'b1;
      pp_done <= 1'b0;
    end else if (cs_s) begin
      bits    <= '0;
      miso    <= 1'b1;
      pp_done <= 1'b0;
    end else begin
      if (rise) begin
        sh <= rx_byte[6:0];
        if (bits != 6'h3f) bits <= bits + 6'd1;
        if (state == CMD && bits == 6'd7) op <= rx_byte;
        if (state == ADDR) addr <= {addr[AW-2:0], mosi_s};
        if (state == RD_DATA && idx == 3'd7) addr <= addr + AW'(1);
        // program address wraps inside its 256-byte page
        if (pp_we) begin
          addr    <= (addr & ~PMASK) | ((addr + AW'(1)) & PMASK);
          pp_done <= 1'b1;
        end
      end
      if (fall) begin
        if (state == RD_DATA || state == STATUS) begin
          if (idx == 3'd0) begin
            tx   <= src;
            miso <= src[7];
          end else begin
            miso <= tx[~idx];
          end
        end else begin
          miso <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bg == ERASE_RUN) mem[ea] <= 8'hff;
    else if (pp_we)      mem[addr] <= mem[addr] & rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bg  <= BG_IDLE;
      wel <= 1'b0;
      cnt <= '0;
      ea  <= '0;
    end else begin
      unique case (bg)
        PROG_RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) bg <= BG_IDLE;
        end
        ERASE_RUN: begin
          ea <= ea + AW'(1);
          if (ea == AW'(MEM_BYTES - 1)) bg <= BG_IDLE;
        end
        default: ;
      endcase
      if (cs_rise) begin
        if (bits == 6'd8 && op == OP_WREN && !wip) wel <= 1'b1;
        if (pp_done) begin
          wel <= 1'b0;
          bg  <= PROG_RUN;
          cnt <= CW'(BUSY_CYCLES);
        end
        if (bits == 6'd8 && op == OP_CE && wel && !wip) begin
          wel <= 1'b0;
          bg  <= ERASE_RUN;
          ea  <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: scoreboard bench issuing SPI flash transactions.
// Define SPI_RESP_FAST_READ_EN to cover the FAST_READ path as well.
module tb_spi_flash_responder;
  localparam int MEM  = 256;
  localparam int BUSY = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wip, wel;

  spi_flash_responder_if spi();

  spi_flash_responder #(
    .MEM_BYTES  (MEM),
    .BUSY_CYCLES(BUSY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi(spi),
    .wip(wip),
    .wel(wel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] mem_m [MEM];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  task automatic xfer(input logic [7:0] b, input int n,
                      output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      spi.s_mosi = b[i];
      repeat (3) @(negedge clk);
      spi.s_sclk = 1'b1;
      r[i] = spi.s_miso;
      repeat (4) @(negedge clk);
      spi.s_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    @(negedge clk);
    spi.s_cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_up();
    repeat (4) @(negedge clk);
    spi.s_cs = 1'b1;
  endtask

  task automatic cs_hi();
    cs_up();
    repeat (8) @(negedge clk);
  endtask

  task automatic txn(input logic [7:0] op, input int naddr,
                     input logic [23:0] a, input int ndum, input int n);
    logic [7:0] r;
    cs_lo();
    xfer(op, 8, r);
    if (naddr > 0) begin
      xfer(a[23:16], 8, r);
      xfer(a[15:8], 8, r);
      xfer(a[7:0], 8, r);
    end
    for (int i = 0; i < ndum; i++) xfer(8'h00, 8, r);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, 8, r);
      got_q.push_back(r);
    end
    cs_hi();
  endtask

  task automatic wren();
    logic [7:0] r;
    cs_lo();
    xfer(8'h06, 8, r);
    cs_hi();
  endtask

  task automatic pp(input logic [23:0] a, input int n,
                    input logic [7:0] b0, input logic [7:0] b1,
                    input logic [7:0] b2);
    logic [7:0] r;
    cs_lo();
    xfer(8'h02, 8, r);
    xfer(a[23:16], 8, r);
    xfer(a[15:8], 8, r);
    xfer(a[7:0], 8, r);
    if (n > 0) xfer(b0, 8, r);
    if (n > 1) xfer(b1, 8, r);
    if (n > 2) xfer(b2, 8, r);
    cs_up();
  endtask

  task automatic wait_ready();
    int k = 0;
    while (wip && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (wip) begin
      checks++;
      errors++;
      $display("FAIL wip_timeout: wip=%b want 0", wip);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    spi.s_cs = 1'b1;
    spi.s_sclk = 1'b0;
    spi.s_mosi = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (wip !== 1'b0) begin errors++; $display("FAIL rst_wip: got %b want 0", wip); end
    if (wel !== 1'b0) begin errors++; $display("FAIL rst_wel: got %b want 0", wel); end
    if (spi.s_miso !== 1'b1) begin
      errors++; $display("FAIL rst_miso: got %b want 1", spi.s_miso);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_erase();
    logic [7:0] e, g;
    int k;
    wren();
    exp_q.push_back(8'h02);
    txn(8'h05, 0, 24'h0, 0, 1);
    cs_lo();
    xfer(8'h60, 8, g);
    cs_hi();
    exp_q.push_back(8'h01);
    txn(8'h05, 0, 24'h0, 0, 1);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL erase_rdsr: got %h want %h", g, e); end
    end
    g = 8'hxx;
    k = 0;
    while (g !== 8'h00 && k < 20) begin
      txn(8'h05, 0, 24'h0, 0, 1);
      g = got_q.pop_front();
      k++;
    end
    checks++;
    if (g !== 8'h00) begin errors++; $display("FAIL erase_poll: got %h want 00", g); end
    for (int i = 0; i < MEM; i++) begin
      mem_m[i] = 8'hff;
      exp_q.push_back(mem_m[i]);
    end
    txn(8'h03, 3, 24'h0, 0, MEM);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL erase_read: got %h want %h", g, e); end
    end
  endtask

  task automatic test_program();
    logic [7:0] e, g;
    int k = 0;
    int n = 0;
    wren();
    pp(24'h000010, 2, 8'ha5, 8'h3c, 8'h00);
    mem_m[16] = mem_m[16] & 8'ha5;
    mem_m[17] = mem_m[17] & 8'h3c;
    while (!wip && k < 20) begin @(negedge clk); k++; end
    while (wip && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n < BUSY - 3 || n > BUSY + 3) begin
      errors++; $display("FAIL busy_len: got %0d want %0d", n, BUSY);
    end
    repeat (8) @(negedge clk);
    for (int i = 16; i < 19; i++) exp_q.push_back(mem_m[i]);
    txn(8'h03, 3, 24'h000010, 0, 3);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL pp_read: got %h want %h", g, e); end
    end
  endtask

  task automatic test_no_wren();
    logic [7:0] e, g;
    pp(24'h000010, 1, 8'h00, 8'h00, 8'h00);
    repeat (8) @(negedge clk);
    checks += 2;
    if (wel !== 1'b0) begin errors++; $display("FAIL nowren_wel: got %b want 0", wel); end
    if (wip !== 1'b0) begin errors++; $display("FAIL nowren_wip: got %b want 0", wip); end
    exp_q.push_back(mem_m[16]);
    txn(8'h03, 3, 24'h000010, 0, 1);
    wren();
    pp(24'h000010, 1, 8'hf0, 8'h00, 8'h00);
    mem_m[16] = mem_m[16] & 8'hf0;
    repeat (8) @(negedge clk);
    wait_ready();
    exp_q.push_back(mem_m[16]);
    txn(8'h03, 3, 24'h000010, 0, 1);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL and_rule: got %h want %h", g, e); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e, g;
    wren();
    pp(24'h0000ff, 3, 8'h11, 8'h22, 8'h33);
    mem_m[255] = mem_m[255] & 8'h11;
    mem_m[0]   = mem_m[0] & 8'h22;
    mem_m[1]   = mem_m[1] & 8'h33;
    repeat (8) @(negedge clk);
    wait_ready();
    exp_q.push_back(mem_m[255]);
    exp_q.push_back(mem_m[0]);
    exp_q.push_back(mem_m[1]);
    txn(8'h03, 3, 24'h1234ff, 0, 3);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_read: got %h want %h", g, e); end
    end
  endtask

  task automatic test_busy();
    logic [7:0] e, g;
    wren();
    pp(24'h000040, 1, 8'h7e, 8'h00, 8'h00);
    mem_m[64] = mem_m[64] & 8'h7e;
    repeat (8) @(negedge clk);
    wren();
    exp_q.push_back(8'h01);
    txn(8'h05, 0, 24'h0, 0, 1);
    checks++;
    if (wel !== 1'b0) begin errors++; $display("FAIL busy_wren: got %b want 0", wel); end
    wait_ready();
    wren();
    pp(24'h000041, 1, 8'h55, 8'h00, 8'h00);
    mem_m[65] = mem_m[65] & 8'h55;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'hff);
    txn(8'h03, 3, 24'h000040, 0, 1);
    wait_ready();
    exp_q.push_back(mem_m[64]);
    exp_q.push_back(mem_m[65]);
    txn(8'h03, 3, 24'h000040, 0, 2);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL busy_read: got %h want %h", g, e); end
    end
  endtask

  task automatic test_short_wren();
    logic [7:0] e, g;
    cs_lo();
    xfer(8'h06, 5, g);
    cs_hi();
    checks++;
    if (wel !== 1'b0) begin errors++; $display("FAIL short_wren: got %b want 0", wel); end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    txn(8'h05, 0, 24'h0, 0, 2);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL short_rdsr: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid_erase();
    logic [7:0] e, g;
    wren();
    cs_lo();
    xfer(8'h60, 8, g);
    cs_up();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 3;
    if (wip !== 1'b0) begin errors++; $display("FAIL rst_erase_wip: got %b want 0", wip); end
    if (wel !== 1'b0) begin errors++; $display("FAIL rst_erase_wel: got %b want 0", wel); end
    if (spi.s_miso !== 1'b1) begin
      errors++; $display("FAIL rst_erase_miso: got %b want 1", spi.s_miso);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 80; i++) mem_m[i] = 8'hff;
    for (int i = 0; i < 4; i++) exp_q.push_back(mem_m[(254 + i) % MEM]);
    txn(8'h03, 3, 24'h0000fe, 0, 4);
    exp_q.push_back(mem_m[16]);
    exp_q.push_back(mem_m[17]);
    txn(8'h03, 3, 24'h000010, 0, 2);
    exp_q.push_back(mem_m[64]);
    exp_q.push_back(mem_m[65]);
    txn(8'h03, 3, 24'h000040, 0, 2);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL partial_erase: got %h want %h", g, e); end
    end
  endtask

  task automatic test_fast_read();
    logic [7:0] e, g;
    wren();
    pp(24'h000010, 1, 8'ha5, 8'h00, 8'h00);
    mem_m[16] = mem_m[16] & 8'ha5;
    repeat (8) @(negedge clk);
    wait_ready();
`ifdef SPI_RESP_FAST_READ_EN
    exp_q.push_back(mem_m[16]);
`else
    exp_q.push_back(8'hff);
`endif
    txn(8'h0b, 3, 24'h000010, 1, 1);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL fast_read: got %h want %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_erase();
    test_program();
    test_no_wren();
    test_wrap();
    test_busy();
    test_short_wren();
    test_reset_mid_erase();
    test_fast_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI flash target emulator: the responder end of the flash command set our SPI flash controller issues (WREN 0x06, RDSR 0x05, PP 0x02, READ 0x03, CE 0x60).
- Holds a small byte array and models the WEL and WIP status bits and program/erase busy time.
- Used as the on-chip/bench flash model so the controller and its command sequencers can be exercised without a physical part.
- SPI mode 0, MSB first; SPI pins are oversampled on the system clock.

Parameters:
- MEM_BYTES, 256: array size in bytes; power of two, 16..4096; address = addr[$clog2(MEM_BYTES)-1:0].
- BUSY_CYCLES, 64: clk cycles WIP stays set after a page program; must be at least 1.

Ports:
- clk  in  1  system clock; must be at least 4x the s_sclk frequency.
- rst  in  1  asynchronous active-high reset.
- s_sclk  in  1  SPI clock from the initiator.
- s_cs  in  1  chip select, active low.
- s_mosi  in  1  data from the initiator.
- s_miso  out  1  data to the initiator; 1 whenever deselected or not driving data.
- wip  out  1  status bit 0, write in progress.
- wel  out  1  status bit 1, write enable latch.

Behaviour:
- Synchronizers: 2-flop synchronizers on s_sclk, s_cs and s_mosi. Edge detect on the synced s_sclk.
- Sampling and drive: on a rising edge while CS is low, shift in MOSI and increment the bit counter. On a falling edge, present the next MISO bit.
- Reset values: s_miso=1, wip=0, wel=0, state=IDLE, all counters 0. The memory array is not reset; contents persist across rst.
- States: IDLE, CMD, ADDR, RD_DATA, PP_DATA, STATUS, IGNORE, ERASE_RUN.
- IDLE -> CMD on the CS falling edge.
- CMD: after 8 bits, decode the opcode:
  - 0x03 -> ADDR.
  - 0x02 -> ADDR if wel=1, else IGNORE.
  - 0x05 -> STATUS.
  - 0x06 and 0x60 -> wait for CS rise.
  - Any other opcode -> IGNORE.
- While wip=1, every opcode except 0x05 goes to IGNORE.
- ADDR: collect 24 bits, then go to RD_DATA or PP_DATA. Address bits above the array width are ignored.
- RD_DATA:
  - The first data MSB is driven on the falling edge after the 32nd rising edge.
  - After each byte the address increments and wraps modulo MEM_BYTES; reads continue without limit.
- PP_DATA:
  - Each completed byte is written as mem[a] <= mem[a] & byte, so programming can only clear bits.
  - Address increments within the 256-byte page: low 8 bits wrap, upper bits are held. If MEM_BYTES < 256, the whole array wraps.
  - A partial trailing byte is discarded.
- STATUS: drives {6'b0, wel, wip} MSB first, repeated every 8 clocks until CS rises. wip is sampled live at each byte boundary.
- CS rising edge: any state -> IDLE, s_miso=1, then the commit rules below apply.
- WREN commit: exactly 8 bits received with opcode 0x06 and wip=0 -> wel=1.
- PP commit: at least one full data byte was written -> wel=0, wip=1, busy counter loaded with BUSY_CYCLES, wip clears when it reaches 0. If no data byte was written, wel is unchanged.
- CE commit: exactly 8 bits, opcode 0x60, wel=1 -> wel=0, wip=1, enter ERASE_RUN.
  - ERASE_RUN writes 0xFF to one address per clk, from 0 to MEM_BYTES-1, then clears wip.
  - In ERASE_RUN, SPI transactions are decoded in parallel; only RDSR responds.
  - The wrong bit count, or wel=0, -> no effect.
- CS rising mid-byte in any state: the partial byte is dropped and the command is aborted unless a commit rule applies.
- rst asserted mid-operation: any erase or program in progress is abandoned. Memory keeps whatever bytes were already written.

Optional Feature:
- Macro SPI_RESP_FAST_READ_EN.
- When defined, opcode 0x0B (FAST_READ) is accepted: 24 address bits, then 8 dummy clocks (MOSI ignored, s_miso=1), then data exactly as READ. Adds a DUMMY state.
- When undefined, 0x0B goes to IGNORE like any unknown opcode.

Test Plan:
- Sequence WREN, then CE, poll RDSR until 0x00: RDSR reads 0x02 after WREN, 0x01 during the erase and 0x00 at the end; READ at addr 0 then returns 0xFF for all MEM_BYTES bytes.
- Sequence WREN, then PP at addr 0x000010 with data 0xA5 and 0x3C, poll until wip=0, then READ at 0x10: returns 0xA5, 0x3C, 0xFF. wip stays high for BUSY_CYCLES clks (±3 for sync latency).
- PP without a prior WREN, then READ: memory is unchanged and wel=0. A second PP of 0xF0 over 0xA5 reads back 0xA0 (AND rule).
- READ starting at MEM_BYTES-1 for 2 bytes: returns mem[MEM_BYTES-1] then mem[0] (wrap). A PP of 3 bytes at page offset 0xFF wraps to offsets 0x00 and 0x01 of the same page.
- During wip=1: READ returns all 1s and WREN has no effect (RDSR = 0x01). CS is raised after 5 bits of WREN: wel stays 0.
- rst pulsed mid-erase: wip=0 and wel=0 immediately and s_miso=1. Bytes already erased read 0xFF and the rest are unchanged. With SPI_RESP_FAST_READ_EN defined, 0x0B at 0x10 plus a dummy byte returns 0xA5.
